// File: rtl/famiclone_detect.sv
// famiclone_detect: tells a standard console from a famiclone (Dendy-style)
// by watching how the /A13 pad reads back during PPU reads. The block first
// grounds CIRAM /CE and /A13 for a fixed number of m2 edges, then releases
// /A13 and compares its read-back level against A13 on every PPU read.
module famiclone_detect #(
    parameter int INIT_CYCLES        = 15,
    parameter int SAMPLES            = 3,
    parameter int MISMATCH_THRESHOLD = 1,
    parameter int TIMEOUT_CYCLES     = 65535,
    parameter int SYNC_STAGES        = 2
) (
    input  logic       m2,
    input  logic       reset,
    input  logic       ppu_rd_in,
    input  logic       ppu_a13,
    input  logic       ppu_not_a13_in,
    input  logic       redetect,
    output logic       ciram_ce_force_low,
    output logic       not_a13_force_low,
    output logic       new_dendy,
    output logic       locked,
    output logic       timed_out,
    output logic [1:0] state
);

    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int SMP_W  = $clog2(SAMPLES + 1);
    localparam int MIS_W  = $clog2(MISMATCH_THRESHOLD + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(INIT_CYCLES);
    localparam logic [SMP_W-1:0]  SMP_MAX   = SMP_W'(SAMPLES);
    localparam logic [MIS_W-1:0]  MIS_MAX   = MIS_W'(MISMATCH_THRESHOLD);
    localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_INIT      = 2'd0,
        ST_DETECT    = 2'd1,
        ST_STANDARD  = 2'd2,
        ST_NEW_DENDY = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] rd_sync, a13_sync, na13_sync;
    logic rd_s, a13_s, na13_s;

    logic [INIT_W-1:0] init_cnt;
    logic [SMP_W-1:0]  lo_cnt, hi_cnt, lo_inc, hi_inc;
    logic [MIS_W-1:0]  mis_cnt, mis_inc;
    logic [TMO_W-1:0]  tmo_cnt, tmo_inc;
    logic              timed_out_q;
    logic              sample, mismatch, mis_hit, match_done, tmo_hit;

    // Counters never wrap: they stop at their limit.
    function automatic int sat_inc(input int value, input int limit);
        return (value >= limit) ? value : value + 1;
    endfunction

    // Synchronise the asynchronous PPU lines; the reset levels look like an idle bus.
    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            rd_sync   <= '1;
            a13_sync  <= '0;
            na13_sync <= '1;
        end else begin
            rd_sync   <= {rd_sync[SYNC_STAGES-2:0], ppu_rd_in};
            a13_sync  <= {a13_sync[SYNC_STAGES-2:0], ppu_a13};
            na13_sync <= {na13_sync[SYNC_STAGES-2:0], ppu_not_a13_in};
        end
    end

    assign rd_s   = rd_sync[SYNC_STAGES-1];
    assign a13_s  = a13_sync[SYNC_STAGES-1];
    assign na13_s = na13_sync[SYNC_STAGES-1];

    // Classify this edge's sample and form the saturated counter increments.
    always_comb begin
        lo_inc   = lo_cnt;
        hi_inc   = hi_cnt;
        mis_inc  = mis_cnt;
        tmo_inc  = TMO_W'(sat_inc(int'(tmo_cnt), TIMEOUT_CYCLES));
        sample   = (state_q == ST_DETECT) && !rd_s;
        mismatch = sample && (na13_s == a13_s);
        if (mismatch) begin
            mis_inc = MIS_W'(sat_inc(int'(mis_cnt), MISMATCH_THRESHOLD));
        end else if (sample) begin
            if (a13_s) hi_inc = SMP_W'(sat_inc(int'(hi_cnt), SAMPLES));
            else       lo_inc = SMP_W'(sat_inc(int'(lo_cnt), SAMPLES));
        end
        mis_hit    = mismatch && (mis_inc == MIS_MAX);
        match_done = (lo_inc == SMP_MAX) && (hi_inc == SMP_MAX);
        tmo_hit    = (tmo_inc == TMO_MAX);
    end

    // State register.
    always_ff @(posedge m2 or posedge reset) begin
        if (reset) state_q <= ST_INIT;
        else       state_q <= state_d;
    end

    // Next state: a real decision outranks the timeout on the same edge.
    always_comb begin
        state_d = state_q;
        if (redetect) begin
            state_d = ST_INIT;
        end else begin
            case (state_q)
                ST_INIT:   if (init_cnt <= INIT_W'(1)) state_d = ST_DETECT;
                ST_DETECT: begin
                    if (mis_hit)         state_d = ST_NEW_DENDY;
                    else if (match_done) state_d = ST_STANDARD;
                    else if (tmo_hit)    state_d = ST_STANDARD;
                end
                default:   state_d = state_q;
            endcase
        end
    end

    // Counters and the timeout flag; INIT keeps the detect counters cleared.
    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            init_cnt    <= INIT_LOAD;
            lo_cnt      <= '0;
            hi_cnt      <= '0;
            mis_cnt     <= '0;
            tmo_cnt     <= '0;
            timed_out_q <= 1'b0;
        end else if (redetect) begin
            init_cnt    <= INIT_LOAD;
            lo_cnt      <= '0;
            hi_cnt      <= '0;
            mis_cnt     <= '0;
            tmo_cnt     <= '0;
            timed_out_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_cnt != '0) init_cnt <= init_cnt - 1'b1;
                    lo_cnt  <= '0;
                    hi_cnt  <= '0;
                    mis_cnt <= '0;
                    tmo_cnt <= '0;
                end
                ST_DETECT: begin
                    lo_cnt  <= lo_inc;
                    hi_cnt  <= hi_inc;
                    mis_cnt <= mis_inc;
                    tmo_cnt <= tmo_inc;
                    if (tmo_hit && !mis_hit && !match_done) timed_out_q <= 1'b1;
                end
                default: begin
                    init_cnt <= init_cnt;
                end
            endcase
        end
    end

    // Outputs are decoded purely from the current state.
    always_comb begin
        ciram_ce_force_low = (state_q == ST_INIT);
        not_a13_force_low  = (state_q == ST_INIT);
        new_dendy          = (state_q == ST_NEW_DENDY);
        locked             = (state_q == ST_STANDARD) || (state_q == ST_NEW_DENDY);
        timed_out          = timed_out_q;
        state              = state_q;
    end

endmodule
